decode_stage_p: RTL and testbench

Parametrised decode stage for the 20-bit-instruction pipeline, the successor to the fixed-width 20/22-bit decode cycle. It decodes the instruction, reads a NUM_REGS-entry register file with write-through bypass from writeback, and sign-extends the immediate. It detects load-use hazards and registers everything into an ID/EX pipeline register with stall and flush control. It sits between the IF/ID register and the execute stage.

---
 rtl/decode_pkg.sv | 75 +++++++
 rtl/reg_file_p.sv | 48 ++++
 rtl/decode_stage_p.sv | 149 ++++++++++++++
 tb/tb_decode_stage_p.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: shared types and helpers for the decode stage.
//   opcode_e   - 4-bit instruction opcode
//   alu_ctrl_t - 3-bit ALU operation select
//   ctrl_t     - decoded control bundle carried into ID/EX
//   *_lsb()    - instruction field offsets as functions of INSTR_W/REG_ADDR_W
package decode_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_ADDI = 4'd5,
        OP_LW   = 4'd6,
        OP_SW   = 4'd7,
        OP_BEQ  = 4'd8
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011
    } alu_ctrl_t;

    typedef struct packed {
        logic      RegWrite;
        logic      ALUSrc;
        logic      MemWrite;
        logic      ResultSrc;
        logic      Branch;
        logic      Illegal;
        alu_ctrl_t ALUControl;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    // Field layout, MSB first: opcode[4] | rd | rs1 | rs2 | spare LSBs.
    function automatic int rd_lsb(input int iw, input int ra);
        return iw - 4 - ra;
    endfunction

    function automatic int rs1_lsb(input int iw, input int ra);
        return iw - 4 - 2 * ra;
    endfunction

    function automatic int rs2_lsb(input int iw, input int ra);
        return iw - 4 - 3 * ra;
    endfunction

    // Immediate spans rs2 plus the spare LSBs.
    function automatic int imm_w(input int iw, input int ra);
        return iw - 4 - 2 * ra;
    endfunction

    function automatic ctrl_t decode_op(input logic [3:0] op);
        ctrl_t c;
        c = CTRL_NONE;
        case (op)
            OP_NOP:  c = CTRL_NONE;
            OP_ADD:  begin c.RegWrite = 1'b1; c.ALUControl = ALU_ADD; end
            OP_SUB:  begin c.RegWrite = 1'b1; c.ALUControl = ALU_SUB; end
            OP_AND:  begin c.RegWrite = 1'b1; c.ALUControl = ALU_AND; end
            OP_OR:   begin c.RegWrite = 1'b1; c.ALUControl = ALU_OR;  end
            OP_ADDI: begin c.RegWrite = 1'b1; c.ALUSrc = 1'b1; end
            OP_LW:   begin c.RegWrite = 1'b1; c.ALUSrc = 1'b1; c.ResultSrc = 1'b1; end
            OP_SW:   begin c.ALUSrc = 1'b1; c.MemWrite = 1'b1; end
            OP_BEQ:  begin c.Branch = 1'b1; c.ALUControl = ALU_SUB; end
            default: c.Illegal = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/reg_file_p.sv
// reg_file_p: NUM_REGS x DATA_W register file, r0 hardwired to zero.
//   clk, rst_n       - clock, async active-low clear of all entries
//   we_i/wa_i/wd_i   - write port (rising edge)
//   ra1_i/ra2_i      - combinational read addresses
//   rd1_o/rd2_o      - read data, with same-cycle write-through bypass
module reg_file_p #(
    parameter int DATA_W     = 22,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [REG_ADDR_W-1:0] wa_i,
    input  logic [DATA_W-1:0]     wd_i,
    input  logic [REG_ADDR_W-1:0] ra1_i,
    input  logic [REG_ADDR_W-1:0] ra2_i,
    output logic [DATA_W-1:0]     rd1_o,
    output logic [DATA_W-1:0]     rd2_o
);

    logic [DATA_W-1:0]                regs_q [NUM_REGS];
    logic [1:0][REG_ADDR_W-1:0]       ra;
    logic [1:0][DATA_W-1:0]           rdata;

    assign ra    = {ra2_i, ra1_i};
    assign rd1_o = rdata[0];
    assign rd2_o = rdata[1];

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (we_i && (wa_i != '0) && (int'(wa_i) < NUM_REGS)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_rd
        always_comb begin
            rdata[p] = '0;
            if (ra[p] == '0 || int'(ra[p]) >= NUM_REGS) rdata[p] = '0;
            else if (we_i && wa_i == ra[p])            rdata[p] = wd_i;
            else                                        rdata[p] = regs_q[ra[p]];
        end
    end

endmodule

// File: rtl/decode_stage_p.sv
// decode_stage_p: instruction decode, register read, immediate extend,
// load-use hazard detection and ID/EX pipeline register.
//   clk, rst                        - clock, async active-low reset
//   InstrD/ValidD/PCD/PCPlus4D      - instruction from IF/ID
//   RegWriteW/RDW/ResultW           - writeback port into the register file
//   stall_i/flush_i                 - hold / bubble the ID/EX register
//   HazardStallD                    - combinational load-use stall request
//   *E outputs                      - registered ID/EX contents
module decode_stage_p
    import decode_pkg::*;
#(
    parameter int INSTR_W    = 20,
    parameter int DATA_W     = 22,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INSTR_W-1:0]    InstrD,
    input  logic                  ValidD,
    input  logic [DATA_W-1:0]     PCD,
    input  logic [DATA_W-1:0]     PCPlus4D,
    input  logic                  RegWriteW,
    input  logic [REG_ADDR_W-1:0] RDW,
    input  logic [DATA_W-1:0]     ResultW,
    input  logic                  stall_i,
    input  logic                  flush_i,
    output logic                  HazardStallD,
    output logic                  ValidE,
    output logic                  RegWriteE,
    output logic                  ALUSrcE,
    output logic                  MemWriteE,
    output logic                  ResultSrcE,
    output logic                  BranchE,
    output logic                  IllegalE,
    output logic [2:0]            ALUControlE,
    output logic [DATA_W-1:0]     RD1_E,
    output logic [DATA_W-1:0]     RD2_E,
    output logic [DATA_W-1:0]     Imm_Ext_E,
    output logic [DATA_W-1:0]     PCE,
    output logic [DATA_W-1:0]     PCPlus4E,
    output logic [REG_ADDR_W-1:0] RS1_E,
    output logic [REG_ADDR_W-1:0] RS2_E,
    output logic [REG_ADDR_W-1:0] RD_E
);

    localparam int RD_LSB  = rd_lsb(INSTR_W, REG_ADDR_W);
    localparam int RS1_LSB = rs1_lsb(INSTR_W, REG_ADDR_W);
    localparam int RS2_LSB = rs2_lsb(INSTR_W, REG_ADDR_W);
    localparam int IMM_W   = imm_w(INSTR_W, REG_ADDR_W);

    typedef struct packed {
        logic                  valid;
        ctrl_t                 ctrl;
        logic [DATA_W-1:0]     rd1;
        logic [DATA_W-1:0]     rd2;
        logic [DATA_W-1:0]     imm;
        logic [DATA_W-1:0]     pc;
        logic [DATA_W-1:0]     pc4;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
    } idex_t;

    logic [3:0]            op;
    logic [REG_ADDR_W-1:0] rd, rs1, rs2;
    logic [IMM_W-1:0]      imm;
    logic [DATA_W-1:0]     rd1, rd2;
    ctrl_t                 ctrl_d;
    logic                  use_rs2;
    idex_t                 idex_q, idex_d;

    assign op  = InstrD[INSTR_W-1 -: 4];
    assign rd  = InstrD[RD_LSB  +: REG_ADDR_W];
    assign rs1 = InstrD[RS1_LSB +: REG_ADDR_W];
    assign rs2 = InstrD[RS2_LSB +: REG_ADDR_W];
    assign imm = InstrD[IMM_W-1:0];

    reg_file_p #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W),
        .NUM_REGS   (NUM_REGS)
    ) u_rf (
        .clk   (clk),
        .rst_n (rst),
        .we_i  (RegWriteW),
        .wa_i  (RDW),
        .wd_i  (ResultW),
        .ra1_i (rs1),
        .ra2_i (rs2),
        .rd1_o (rd1),
        .rd2_o (rd2)
    );

    assign ctrl_d  = ValidD ? decode_op(op) : CTRL_NONE;
    // rs2 is a real source only when the immediate is not used, or for stores.
    assign use_rs2 = !ctrl_d.ALUSrc || ctrl_d.MemWrite;

    // A stall or flush already takes over ID/EX, so no hazard bubble is needed.
    assign HazardStallD = idex_q.valid && idex_q.ctrl.RegWrite && idex_q.ctrl.ResultSrc
                       && (idex_q.rd != '0) && ValidD
                       && ((idex_q.rd == rs1) || (use_rs2 && idex_q.rd == rs2))
                       && !flush_i && !stall_i;

    always_comb begin
        idex_d = idex_q;
        if (flush_i) begin
            idex_d = '0;
        end else if (stall_i) begin
            idex_d = idex_q;
        end else if (HazardStallD) begin
            idex_d = '0;
        end else begin
            idex_d.valid = ValidD;
            idex_d.ctrl  = ctrl_d;
            idex_d.rd1   = rd1;
            idex_d.rd2   = rd2;
            idex_d.imm   = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
            idex_d.pc    = PCD;
            idex_d.pc4   = PCPlus4D;
            idex_d.rs1   = rs1;
            idex_d.rs2   = rs2;
            idex_d.rd    = rd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) idex_q <= '0;
        else      idex_q <= idex_d;
    end

    assign ValidE      = idex_q.valid;
    assign RegWriteE   = idex_q.ctrl.RegWrite;
    assign ALUSrcE     = idex_q.ctrl.ALUSrc;
    assign MemWriteE   = idex_q.ctrl.MemWrite;
    assign ResultSrcE  = idex_q.ctrl.ResultSrc;
    assign BranchE     = idex_q.ctrl.Branch;
    assign IllegalE    = idex_q.ctrl.Illegal;
    assign ALUControlE = idex_q.ctrl.ALUControl;
    assign RD1_E       = idex_q.rd1;
    assign RD2_E       = idex_q.rd2;
    assign Imm_Ext_E   = idex_q.imm;
    assign PCE         = idex_q.pc;
    assign PCPlus4E    = idex_q.pc4;
    assign RS1_E       = idex_q.rs1;
    assign RS2_E       = idex_q.rs2;
    assign RD_E        = idex_q.rd;

endmodule

// File: tb/tb_decode_stage_p.sv
module tb_decode_stage_p;

    localparam int IW = 20;
    localparam int DW = 22;
    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic [IW-1:0] InstrD;
    logic          ValidD;
    logic [DW-1:0] PCD, PCPlus4D, ResultW;
    logic          RegWriteW;
    logic [AW-1:0] RDW;
    logic          stall_i, flush_i;
    logic          HazardStallD, ValidE, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, IllegalE;
    logic [2:0]    ALUControlE;
    logic [DW-1:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
    logic [AW-1:0] RS1_E, RS2_E, RD_E;

    decode_stage_p #(.INSTR_W(IW), .DATA_W(DW), .REG_ADDR_W(AW), .NUM_REGS(32)) dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .ValidD(ValidD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .stall_i(stall_i), .flush_i(flush_i),
        .HazardStallD(HazardStallD), .ValidE(ValidE), .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE),
        .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE), .BranchE(BranchE), .IllegalE(IllegalE),
        .ALUControlE(ALUControlE), .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          v, rw, as, mw, rs, br, il;
        logic [2:0]    alu;
        logic [DW-1:0] rd1, rd2, imm, pc, pc4;
        logic [AW-1:0] s1, s2, d;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    function automatic logic [IW-1:0] enc(input logic [3:0] op, input logic [4:0] d, s1, s2, input logic b0);
        return {op, d, s1, s2, b0};
    endfunction

    function automatic exp_t bub();
        exp_t e;
        e = '{default: '0};
        return e;
    endfunction

    // Expected ID/EX contents for a valid instruction, from the opcode table.
    function automatic exp_t dec(input logic [3:0] op, input logic [4:0] d, s1, s2, input logic b0,
                                 input logic [DW-1:0] r1, r2, pc);
        exp_t e;
        e = bub();
        e.v = 1'b1;
        case (op)
            4'd0: ;
            4'd1: begin e.rw = 1; e.alu = 3'b000; end
            4'd2: begin e.rw = 1; e.alu = 3'b001; end
            4'd3: begin e.rw = 1; e.alu = 3'b010; end
            4'd4: begin e.rw = 1; e.alu = 3'b011; end
            4'd5: begin e.rw = 1; e.as = 1; end
            4'd6: begin e.rw = 1; e.as = 1; e.rs = 1; end
            4'd7: begin e.as = 1; e.mw = 1; end
            4'd8: begin e.br = 1; e.alu = 3'b001; end
            default: e.il = 1;
        endcase
        e.rd1 = r1;
        e.rd2 = r2;
        e.imm = {{16{s2[4]}}, s2, b0};
        e.pc  = pc;
        e.pc4 = pc + 22'd4;
        e.s1  = s1;
        e.s2  = s2;
        e.d   = d;
        return e;
    endfunction

    task automatic drive(input logic [3:0] op, input logic [4:0] d, s1, s2, input logic b0, input logic [DW-1:0] pc);
        InstrD   = enc(op, d, s1, s2, b0);
        ValidD   = 1'b1;
        PCD      = pc;
        PCPlus4D = pc + 22'd4;
    endtask

    // Advance one edge, then pop the scoreboard and compare the ID/EX outputs.
    task automatic tick_check(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s scoreboard empty observed=none expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".ValidE"},      ValidE,      e.v);
            chk({tag, ".RegWriteE"},   RegWriteE,   e.rw);
            chk({tag, ".ALUSrcE"},     ALUSrcE,     e.as);
            chk({tag, ".MemWriteE"},   MemWriteE,   e.mw);
            chk({tag, ".ResultSrcE"},  ResultSrcE,  e.rs);
            chk({tag, ".BranchE"},     BranchE,     e.br);
            chk({tag, ".IllegalE"},    IllegalE,    e.il);
            chk({tag, ".ALUControlE"}, ALUControlE, e.alu);
            chk({tag, ".RD1_E"},       RD1_E,       e.rd1);
            chk({tag, ".RD2_E"},       RD2_E,       e.rd2);
            chk({tag, ".Imm_Ext_E"},   Imm_Ext_E,   e.imm);
            chk({tag, ".PCE"},         PCE,         e.pc);
            chk({tag, ".PCPlus4E"},    PCPlus4E,    e.pc4);
            chk({tag, ".RS1_E"},       RS1_E,       e.s1);
            chk({tag, ".RS2_E"},       RS2_E,       e.s2);
            chk({tag, ".RD_E"},        RD_E,        e.d);
        end
    endtask

    initial begin
        // Reset held with random inputs.
        rst       = 1'b0;
        InstrD    = IW'($urandom);
        ValidD    = 1'b1;
        PCD       = DW'($urandom);
        PCPlus4D  = DW'($urandom);
        RegWriteW = 1'b1;
        RDW       = AW'($urandom_range(1, 31));
        ResultW   = DW'($urandom);
        stall_i   = 1'($urandom);
        flush_i   = 1'b0;
        #3;
        chk("rst.ValidE", ValidE, 0);
        chk("rst.RegWriteE", RegWriteE, 0);
        chk("rst.RD1_E", RD1_E, 0);
        chk("rst.PCE", PCE, 0);
        chk("rst.RD_E", RD_E, 0);
        chk("rst.HazardStallD", HazardStallD, 0);
        @(posedge clk);
        #1;
        chk("rst_edge.ValidE", ValidE, 0);
        chk("rst_edge.Imm_Ext_E", Imm_Ext_E, 0);

        // Release with idle inputs.
        InstrD = '0; ValidD = 0; PCD = '0; PCPlus4D = '0;
        RegWriteW = 0; RDW = '0; ResultW = '0; stall_i = 0; flush_i = 0;
        rst = 1'b1;
        sb.push_back(bub()); tick_check("idle");

        // Fill r1=5, r2=3 through writeback.
        RegWriteW = 1; RDW = 5'd1; ResultW = 22'h00005;
        sb.push_back(bub()); tick_check("wr_r1");
        RDW = 5'd2; ResultW = 22'h00003;
        sb.push_back(bub()); tick_check("wr_r2");
        RegWriteW = 0;

        drive(4'd1, 5'd4, 5'd1, 5'd2, 1'b0, 22'h100);
        sb.push_back(dec(4'd1, 5'd4, 5'd1, 5'd2, 1'b0, 22'h5, 22'h3, 22'h100)); tick_check("add");

        // Same-cycle bypass of r7 plus negative immediate.
        RegWriteW = 1; RDW = 5'd7; ResultW = 22'h0000F;
        drive(4'd5, 5'd8, 5'd7, 5'd31, 1'b0, 22'h104);
        sb.push_back(dec(4'd5, 5'd8, 5'd7, 5'd31, 1'b0, 22'hF, 22'h0, 22'h104)); tick_check("addi_byp");
        chk("addi.imm_value", Imm_Ext_E, 32'h3FFFFE);
        RegWriteW = 0;

        drive(4'd3, 5'd9, 5'd7, 5'd1, 1'b1, 22'h108);
        sb.push_back(dec(4'd3, 5'd9, 5'd7, 5'd1, 1'b1, 22'hF, 22'h5, 22'h108)); tick_check("and_r7");

        // Load-use on rs1: one bubble, then ADD proceeds.
        drive(4'd6, 5'd3, 5'd1, 5'd0, 1'b0, 22'h10C);
        sb.push_back(dec(4'd6, 5'd3, 5'd1, 5'd0, 1'b0, 22'h5, 22'h0, 22'h10C)); tick_check("lw");
        drive(4'd1, 5'd5, 5'd3, 5'd2, 1'b0, 22'h110);
        #1 chk("lu.haz_on", HazardStallD, 1);
        sb.push_back(bub()); tick_check("lu_bubble");
        chk("lu.haz_off", HazardStallD, 0);
        sb.push_back(dec(4'd1, 5'd5, 5'd3, 5'd2, 1'b0, 22'h0, 22'h3, 22'h110)); tick_check("lu_add");

        // Load-use through rs2 of a store.
        drive(4'd6, 5'd3, 5'd1, 5'd0, 1'b0, 22'h114);
        sb.push_back(dec(4'd6, 5'd3, 5'd1, 5'd0, 1'b0, 22'h5, 22'h0, 22'h114)); tick_check("lw2");
        drive(4'd7, 5'd0, 5'd1, 5'd3, 1'b0, 22'h118);
        #1 chk("sw.haz_on", HazardStallD, 1);
        sb.push_back(bub()); tick_check("sw_bubble");
        sb.push_back(dec(4'd7, 5'd0, 5'd1, 5'd3, 1'b0, 22'h5, 22'h0, 22'h118)); tick_check("sw");

        // ADDI's rs2 field is immediate: no hazard.
        drive(4'd6, 5'd3, 5'd1, 5'd0, 1'b0, 22'h11C);
        sb.push_back(dec(4'd6, 5'd3, 5'd1, 5'd0, 1'b0, 22'h5, 22'h0, 22'h11C)); tick_check("lw3");
        drive(4'd5, 5'd4, 5'd1, 5'd3, 1'b0, 22'h120);
        #1 chk("addi.no_haz", HazardStallD, 0);
        sb.push_back(dec(4'd5, 5'd4, 5'd1, 5'd3, 1'b0, 22'h5, 22'h0, 22'h120)); tick_check("addi_nohaz");

        // Stall beats hazard: hold LW, no HazardStallD.
        drive(4'd6, 5'd3, 5'd1, 5'd0, 1'b0, 22'h124);
        sb.push_back(dec(4'd6, 5'd3, 5'd1, 5'd0, 1'b0, 22'h5, 22'h0, 22'h124)); tick_check("lw4");
        drive(4'd1, 5'd5, 5'd3, 5'd2, 1'b0, 22'h128);
        stall_i = 1;
        #1 chk("stall.haz_off", HazardStallD, 0);
        sb.push_back(dec(4'd6, 5'd3, 5'd1, 5'd0, 1'b0, 22'h5, 22'h0, 22'h124)); tick_check("stall_hold");

        // Flush beats stall.
        drive(4'd2, 5'd6, 5'd1, 5'd2, 1'b0, 22'h12C);
        flush_i = 1;
        sb.push_back(bub()); tick_check("flush_stall");
        flush_i = 0; stall_i = 0;
        sb.push_back(dec(4'd2, 5'd6, 5'd1, 5'd2, 1'b0, 22'h5, 22'h3, 22'h12C)); tick_check("sub");

        // r0 write ignored, both bypassed and stored paths.
        RegWriteW = 1; RDW = 5'd0; ResultW = 22'h3FFFFF;
        drive(4'd4, 5'd9, 5'd0, 5'd0, 1'b0, 22'h130);
        sb.push_back(dec(4'd4, 5'd9, 5'd0, 5'd0, 1'b0, 22'h0, 22'h0, 22'h130)); tick_check("r0_byp");
        RegWriteW = 0;
        sb.push_back(dec(4'd4, 5'd9, 5'd0, 5'd0, 1'b0, 22'h0, 22'h0, 22'h130)); tick_check("r0_read");

        // Illegal opcode.
        drive(4'd15, 5'd1, 5'd1, 5'd2, 1'b0, 22'h134);
        sb.push_back(dec(4'd15, 5'd1, 5'd1, 5'd2, 1'b0, 22'h5, 22'h3, 22'h134)); tick_check("illegal");

        // BEQ.
        drive(4'd8, 5'd0, 5'd1, 5'd2, 1'b1, 22'h138);
        sb.push_back(dec(4'd8, 5'd0, 5'd1, 5'd2, 1'b1, 22'h5, 22'h3, 22'h138)); tick_check("beq");

        // Mid-operation async reset clears pipeline and register file.
        drive(4'd1, 5'd4, 5'd1, 5'd2, 1'b0, 22'h200);
        #3 rst = 1'b0;
        #1;
        chk("midrst.ValidE", ValidE, 0);
        chk("midrst.BranchE", BranchE, 0);
        chk("midrst.RD1_E", RD1_E, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        sb.push_back(dec(4'd1, 5'd4, 5'd1, 5'd2, 1'b0, 22'h0, 22'h0, 22'h200)); tick_check("post_rst");

        chk("sb.drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
